// File: rtl/training_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// training_scheduler : sequences forward/training passes over samples and
// epochs, accumulates absolute loss and commits trained weights.
// Revision: 1.0
// ---------------------------------------------------------------------------
module training_scheduler #(
  parameter int DATA_W    = 16,
  parameter int SAMPLE_AW = 4,
  parameter int EPOCH_W   = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [SAMPLE_AW:0]     num_samples,
  input  logic [EPOCH_W-1:0]     num_epochs,
  input  logic [14*DATA_W-1:0]   init_weights,
  output logic [SAMPLE_AW-1:0]   sample_idx,
  input  logic [DATA_W-1:0]      label,
  output logic                   fwd_start,
  input  logic                   fwd_done,
  input  logic [DATA_W-1:0]      fwd_output,
  output logic                   train_start,
  input  logic                   train_done,
  input  logic [14*DATA_W-1:0]   trained_weights,
  output logic [14*DATA_W-1:0]   active_weights,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [EPOCH_W-1:0]     epoch,
  output logic [23:0]            loss_acc
);

  localparam int LOSS_W = 24;
  localparam int NW     = 14 * DATA_W;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]     TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = 1;
  localparam logic [SAMPLE_AW:0]   NS_ONE   = 1;
  localparam logic [SAMPLE_AW-1:0] IDX_ONE  = 1;
  localparam logic [EPOCH_W-1:0]   EP_ONE   = 1;

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_FWD_START   = 4'd1,
    S_FWD_WAIT    = 4'd2,
    S_TRAIN_START = 4'd3,
    S_TRAIN_WAIT  = 4'd4,
    S_COMMIT      = 4'd5,
    S_NEXT        = 4'd6,
    S_DONE        = 4'd7,
    S_ERR         = 4'd8
  } state_t;

  state_t               state_q, state_d;
  logic [SAMPLE_AW-1:0] sample_idx_q, sample_idx_d;
  logic [EPOCH_W-1:0]   epoch_q, epoch_d;
  logic [LOSS_W-1:0]    loss_acc_q, loss_acc_d;
  logic [NW-1:0]        weights_q, weights_d;
  logic                 error_q, error_d;
  logic [CNT_W-1:0]     tmo_q, tmo_d;
  logic [SAMPLE_AW:0]   num_samples_q, num_samples_d;
  logic [EPOCH_W-1:0]   num_epochs_q, num_epochs_d;

  // Signed difference is one bit wider than the operands so it never overflows.
  logic [DATA_W:0]   w_diff;
  logic [DATA_W:0]   w_abs;
  logic [LOSS_W:0]   w_loss_sum;
  logic [LOSS_W-1:0] w_loss_sat;
  logic              w_last_sample;
  logic [EPOCH_W-1:0] w_epoch_inc;

  always_comb begin
    w_diff        = {label[DATA_W-1], label} - {fwd_output[DATA_W-1], fwd_output};
    w_abs         = w_diff[DATA_W] ? (~w_diff + 1'b1) : w_diff;
    w_loss_sum    = {1'b0, loss_acc_q} + {{(LOSS_W - DATA_W){1'b0}}, w_abs};
    w_loss_sat    = w_loss_sum[LOSS_W] ? {LOSS_W{1'b1}} : w_loss_sum[LOSS_W-1:0];
    // All-ones index also wraps so an oversized sample count cannot run forever.
    w_last_sample = ({1'b0, sample_idx_q} == (num_samples_q - NS_ONE)) || (&sample_idx_q);
    w_epoch_inc   = epoch_q + EP_ONE;
  end

  always_comb begin
    state_d       = state_q;
    sample_idx_d  = sample_idx_q;
    epoch_d       = epoch_q;
    loss_acc_d    = loss_acc_q;
    weights_d     = weights_q;
    error_d       = error_q;
    tmo_d         = tmo_q;
    num_samples_d = num_samples_q;
    num_epochs_d  = num_epochs_q;

    if ((state_q != S_IDLE) && abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if ((num_samples == '0) || (num_epochs == '0)) begin
              state_d = S_DONE;
            end else begin
              weights_d     = init_weights;
              sample_idx_d  = '0;
              epoch_d       = '0;
              loss_acc_d    = '0;
              error_d       = 1'b0;
              num_samples_d = num_samples;
              num_epochs_d  = num_epochs;
              state_d       = S_FWD_START;
            end
          end
        end
        S_FWD_START: begin
          tmo_d   = '0;
          state_d = S_FWD_WAIT;
        end
        S_FWD_WAIT: begin
          if (fwd_done) begin
            loss_acc_d = w_loss_sat;
            state_d    = S_TRAIN_START;
          end else if (tmo_q == TMO_LAST) begin
            error_d = 1'b1;
            state_d = S_ERR;
          end else begin
            tmo_d = tmo_q + CNT_ONE;
          end
        end
        S_TRAIN_START: begin
          tmo_d   = '0;
          state_d = S_TRAIN_WAIT;
        end
        S_TRAIN_WAIT: begin
          if (train_done) begin
            state_d = S_COMMIT;
          end else if (tmo_q == TMO_LAST) begin
            error_d = 1'b1;
            state_d = S_ERR;
          end else begin
            tmo_d = tmo_q + CNT_ONE;
          end
        end
        S_COMMIT: begin
          weights_d = trained_weights;
          state_d   = S_NEXT;
        end
        S_NEXT: begin
          if (w_last_sample) begin
            sample_idx_d = '0;
            epoch_d      = w_epoch_inc;
            state_d      = (w_epoch_inc == num_epochs_q) ? S_DONE : S_FWD_START;
          end else begin
            sample_idx_d = sample_idx_q + IDX_ONE;
            state_d      = S_FWD_START;
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_ERR:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      sample_idx_q  <= '0;
      epoch_q       <= '0;
      loss_acc_q    <= '0;
      weights_q     <= '0;
      error_q       <= 1'b0;
      tmo_q         <= '0;
      num_samples_q <= '0;
      num_epochs_q  <= '0;
    end else begin
      state_q       <= state_d;
      sample_idx_q  <= sample_idx_d;
      epoch_q       <= epoch_d;
      loss_acc_q    <= loss_acc_d;
      weights_q     <= weights_d;
      error_q       <= error_d;
      tmo_q         <= tmo_d;
      num_samples_q <= num_samples_d;
      num_epochs_q  <= num_epochs_d;
    end
  end

  assign fwd_start      = (state_q == S_FWD_START);
  assign train_start    = (state_q == S_TRAIN_START);
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE) || (state_q == S_ERR);
  assign error          = error_q;
  assign sample_idx     = sample_idx_q;
  assign epoch          = epoch_q;
  assign loss_acc       = loss_acc_q;
  assign active_weights = weights_q;

endmodule
`default_nettype wire

// File: tb/tb_training_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_training_scheduler : directed self-checking bench with simple
// forward/training pipeline models.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_training_scheduler;

  localparam int DW  = 16;
  localparam int AW  = 4;
  localparam int EW  = 8;
  localparam int TMO = 16;
  localparam int NW  = 14 * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW:0]   num_samples = '0;
  logic [EW-1:0] num_epochs = '0;
  logic [NW-1:0] init_weights;
  logic [AW-1:0] sample_idx;
  logic [DW-1:0] label;
  logic          fwd_start;
  logic          fwd_done = 1'b0;
  logic [DW-1:0] fwd_output = 16'd1152;
  logic          train_start;
  logic          train_done = 1'b0;
  logic [NW-1:0] trained_weights;
  logic [NW-1:0] active_weights;
  logic          busy, done, error;
  logic [EW-1:0] epoch;
  logic [23:0]   loss_acc;

  training_scheduler #(
    .DATA_W(DW), .SAMPLE_AW(AW), .EPOCH_W(EW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_samples(num_samples), .num_epochs(num_epochs),
    .init_weights(init_weights), .sample_idx(sample_idx), .label(label),
    .fwd_start(fwd_start), .fwd_done(fwd_done), .fwd_output(fwd_output),
    .train_start(train_start), .train_done(train_done),
    .trained_weights(trained_weights), .active_weights(active_weights),
    .busy(busy), .done(done), .error(error), .epoch(epoch), .loss_acc(loss_acc)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (sample_idx)
      4'd0:    label = 16'd512;
      4'd1:    label = 16'd2000;
      4'd2:    label = 16'hFF00;
      default: label = 16'd0;
    endcase
  end

  int tests_run = 0;
  int tests_failed = 0;

  int cyc = 0, fwd_pulses = 0, train_pulses = 0, done_pulses = 0;
  int fwd_cyc = 0, done_cyc = 0, fwd_cnt = 0, tr_cnt = 0;
  bit fwd_en = 1'b1;
  logic err_at_done = 1'b0;
  logic [5:0] log_ptr = '0;
  logic [AW-1:0] idx_log [64];

  // Pipeline models and event monitor, all on the falling edge.
  always @(negedge clk) begin
    cyc++;
    fwd_done   = 1'b0;
    train_done = 1'b0;
    if (fwd_cnt > 0) begin
      fwd_cnt--;
      if (fwd_cnt == 0) fwd_done = fwd_en;
    end
    if (tr_cnt > 0) begin
      tr_cnt--;
      if (tr_cnt == 0) train_done = 1'b1;
    end
    if (fwd_start) begin
      idx_log[log_ptr] = sample_idx;
      log_ptr++;
      fwd_pulses++;
      fwd_cyc = cyc;
      fwd_cnt = 5;
    end
    if (train_start) begin
      train_pulses++;
      tr_cnt = 3;
    end
    if (done) begin
      done_pulses++;
      done_cyc    = cyc;
      err_at_done = error;
    end
  end

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int ns, input int ne);
    num_samples = ns[AW:0];
    num_epochs  = ne[EW-1:0];
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input string tag);
    for (int k = 0; k < 500 && done_pulses == base; k++) tick();
    check_val(tag, 256'(done_pulses - base), 256'd1);
  endtask

  logic [NW-1:0] init_w, tr_w;
  int b_fwd, b_tr, b_done, b_ptr, c0;
  logic [23:0] seq;

  initial begin
    for (int i = 0; i < 14; i++) begin
      init_w[i*DW +: DW] = (i < 9) ? 16'd64 : ((i < 13) ? 16'd128 : 16'd0);
      tr_w[i*DW +: DW]   = 16'h0100 + 16'(i);
    end
    init_weights    = init_w;
    trained_weights = tr_w;

    // Reset state
    repeat (3) tick();
    check_val("rst_busy", 256'(busy), 256'd0);
    check_val("rst_done", 256'(done), 256'd0);
    check_val("rst_error", 256'(error), 256'd0);
    check_val("rst_starts", 256'({fwd_start, train_start}), 256'd0);
    check_val("rst_weights", 256'(active_weights), 256'd0);
    check_val("rst_counters", 256'({sample_idx, epoch, loss_acc}), 256'd0);
    rst_n = 1'b1;
    tick();

    // Single sample, single epoch
    b_fwd = fwd_pulses; b_tr = train_pulses; b_done = done_pulses;
    start_run(1, 1);
    check_val("busy_after_start", 256'(busy), 256'd1);
    wait_done(b_done, "t1_done_seen");
    tick();
    check_val("t1_fwd_pulses", 256'(fwd_pulses - b_fwd), 256'd1);
    check_val("t1_train_pulses", 256'(train_pulses - b_tr), 256'd1);
    check_val("t1_loss", 256'(loss_acc), 256'd640);
    check_val("t1_weights", 256'(active_weights), 256'(tr_w));
    check_val("t1_epoch", 256'(epoch), 256'd1);
    check_val("t1_busy", 256'(busy), 256'd0);
    check_val("t1_done_count", 256'(done_pulses - b_done), 256'd1);

    // Three samples, two epochs, with a negative label
    b_fwd = fwd_pulses; b_tr = train_pulses; b_done = done_pulses; b_ptr = int'(log_ptr);
    start_run(3, 2);
    wait_done(b_done, "t2_done_seen");
    tick();
    check_val("t2_fwd_pulses", 256'(fwd_pulses - b_fwd), 256'd6);
    check_val("t2_train_pulses", 256'(train_pulses - b_tr), 256'd6);
    seq = '0;
    for (int k = 0; k < 6; k++) seq[k*4 +: 4] = idx_log[6'(b_ptr + k)];
    check_val("t2_idx_seq", 256'(seq), 256'h210210);
    check_val("t2_epoch", 256'(epoch), 256'd2);
    check_val("t2_loss", 256'(loss_acc), 256'd5792);
    check_val("t2_idx_wrap", 256'(sample_idx), 256'd0);

    // Zero epochs
    b_fwd = fwd_pulses; b_tr = train_pulses; b_done = done_pulses;
    c0 = cyc;
    start_run(1, 0);
    repeat (3) tick();
    check_val("t3_done_count", 256'(done_pulses - b_done), 256'd1);
    check_val("t3_latency_le2", 256'((done_cyc - c0) <= 2), 256'd1);
    check_val("t3_no_starts", 256'((fwd_pulses - b_fwd) + (train_pulses - b_tr)), 256'd0);

    // Forward pipeline timeout
    fwd_en = 1'b0;
    b_tr = train_pulses; b_done = done_pulses;
    start_run(1, 1);
    wait_done(b_done, "t4_done_seen");
    tick();
    check_val("t4_done_latency", 256'(done_cyc - fwd_cyc), 256'd17);
    check_val("t4_err_at_done", 256'(err_at_done), 256'd1);
    check_val("t4_error_sticky", 256'(error), 256'd1);
    check_val("t4_weights", 256'(active_weights), 256'(init_w));
    check_val("t4_no_train", 256'(train_pulses - b_tr), 256'd0);
    fwd_en = 1'b1;
    repeat (10) tick();

    // Abort coincident with train_done
    b_done = done_pulses;
    start_run(1, 1);
    check_val("t5_error_cleared", 256'(error), 256'd0);
    for (int k = 0; k < 100 && !train_done; k++) begin
      @(negedge clk);
      #1;
    end
    check_val("t5_train_done_seen", 256'(train_done), 256'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("t5_idle", 256'(busy), 256'd0);
    repeat (5) tick();
    check_val("t5_no_commit", 256'(active_weights), 256'(init_w));
    check_val("t5_no_done", 256'(done_pulses - b_done), 256'd0);
    check_val("t5_loss", 256'(loss_acc), 256'd640);

    // Asynchronous reset mid-run
    b_fwd = fwd_pulses;
    start_run(3, 2);
    for (int k = 0; k < 200 && fwd_pulses < b_fwd + 2; k++) tick();
    tick();
    check_val("t6_busy_before", 256'(busy), 256'd1);
    rst_n = 1'b0;
    #1;
    check_val("t6_busy", 256'(busy), 256'd0);
    check_val("t6_weights", 256'(active_weights), 256'd0);
    check_val("t6_counters", 256'({sample_idx, epoch, loss_acc}), 256'd0);
    check_val("t6_flags", 256'({fwd_start, train_start, done, error}), 256'd0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/training_scheduler.md
TRAINING_SCHEDULER -- requirements
Module: training_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 16, Q8.8 word width for weights, outputs and labels.
REQ-002 SHALL have parameter SAMPLE_AW, default 4, sample index width (up to 16 samples).
REQ-003 SHALL have parameter EPOCH_W, default 8, epoch counter width.
REQ-004 SHALL have parameter TIMEOUT, default 1024, maximum cycles to wait for any pipeline done.
REQ-005 SHALL have ports clk (input, 1, sole clock) and rst_n (input, 1); one clock, reset asynchronous and active-low.
REQ-006 SHALL have start (in, 1, pulse to begin a run) and abort (in, 1, pulse to stop a run).
REQ-007 SHALL have num_samples (in, SAMPLE_AW+1, samples per epoch) and num_epochs (in, EPOCH_W, epochs per run).
REQ-008 SHALL have init_weights (in, 14*DATA_W, kernel[0..8], fc_w[0..3], fc_bias packed LSB-first, in that order).
REQ-009 SHALL have sample_idx (out, SAMPLE_AW, address to the sample/label store) and label (in, DATA_W, label of sample_idx).
REQ-010 SHALL have fwd_start (out, 1), fwd_done (in, 1) and fwd_output (in, DATA_W, signed) to the forward pipeline.
REQ-011 SHALL have train_start (out, 1), train_done (in, 1) and trained_weights (in, 14*DATA_W, same packing) to the training pipeline.
REQ-012 SHALL have active_weights (out, 14*DATA_W), feeding both pipelines.
REQ-013 SHALL have busy (out, 1), done (out, 1, one-cycle pulse), error (out, 1, sticky timeout flag), epoch (out, EPOCH_W) and loss_acc (out, 24, unsigned).

Function
REQ-014 SHALL implement states IDLE, FWD_START, FWD_WAIT, TRAIN_START, TRAIN_WAIT, COMMIT, NEXT, DONE, ERR.
REQ-015 In IDLE with start=1 and both counts nonzero: load active_weights<=init_weights, clear sample_idx, epoch, loss_acc and error, go to FWD_START.
REQ-016 If start=1 with num_samples=0 or num_epochs=0: go to DONE and issue no fwd_start or train_start.
REQ-017 SHALL ignore start whenever state is not IDLE.
REQ-018 fwd_start SHALL be high for exactly the one cycle spent in FWD_START; train_start likewise in TRAIN_START.
REQ-019 In FWD_WAIT on fwd_done=1: add |label - fwd_output| (17-bit signed difference) to loss_acc, saturating at 2^24-1, then go to TRAIN_START.
REQ-020 In TRAIN_WAIT on train_done=1: go to COMMIT; COMMIT SHALL copy trained_weights into active_weights in one cycle.
REQ-021 NEXT SHALL increment sample_idx; at num_samples-1 it SHALL wrap sample_idx to 0 and increment epoch.
REQ-022 NEXT SHALL go to DONE when the incremented epoch equals num_epochs, otherwise to FWD_START.
REQ-023 sample_idx and active_weights SHALL stay constant from FWD_START through TRAIN_WAIT.
REQ-024 DONE SHALL pulse done for one cycle and return to IDLE; epoch, loss_acc and active_weights SHALL hold until the next accepted start.
REQ-025 Each of FWD_WAIT and TRAIN_WAIT SHALL count cycles; at TIMEOUT cycles without done, go to ERR and set error.
REQ-026 ERR SHALL pulse done and return to IDLE; error SHALL stay set until the next accepted start.
REQ-027 abort=1 in any non-IDLE state SHALL return to IDLE next cycle without pulsing done; active_weights SHALL hold the last committed value.
REQ-028 If abort and a pipeline done arrive in the same cycle, abort SHALL win and no loss update or commit SHALL occur.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 fwd_done and train_done arriving outside their wait states SHALL be ignored.

Reset
REQ-031 rst_n=0 SHALL asynchronously force state IDLE and set fwd_start, train_start, busy, done, error, sample_idx, epoch, loss_acc and active_weights to 0; reset mid-run SHALL abandon the run.

Verification
REQ-032 init: input all 256, kernel all 64, fc_w 128, bias 0; label 512; fwd_output model 1152 after 5 cycles; 1 sample, 1 epoch -> one fwd_start, then loss_acc=640, one train_start, active_weights=trained_weights, one done pulse, busy falls.
REQ-033 num_samples=3, num_epochs=2 -> sample_idx sequence 0,1,2,0,1,2; exactly 6 fwd_start and 6 train_start pulses; epoch=2 at done.
REQ-034 num_epochs=0 -> done pulse within 2 cycles of start; zero fwd_start and train_start pulses.
REQ-035 fwd_done never asserted, TIMEOUT=16 -> error=1 and done pulse 17 cycles after fwd_start; active_weights equal to init_weights.
REQ-036 abort in the same cycle as train_done -> IDLE, no commit, no done pulse; rst_n low mid-run -> all outputs 0 immediately.
